// File: rtl/decimal_entry_parser_if.sv
// Key-entry bus between the navigation decoder and the decimal entry parser.
// The master drives key strobes; the slave returns the buffer, status and result.
interface decimal_entry_parser_if #(
   parameter int DIGITS = 2,
   parameter int W_OUT  = 8
);
   logic                   digit_valid;
   logic [3:0]             digit_in;
   logic                   backspace;
   logic                   clear;
   logic                   commit;
   logic [DIGITS-1:0][3:0] digits;
   logic [2:0]             digit_count;
   logic                   busy;
   logic [W_OUT-1:0]       value;
   logic                   done;
   logic                   range_err;

   modport master (
      output digit_valid, digit_in, backspace, clear, commit,
      input  digits, digit_count, busy, value, done, range_err
   );

   modport slave (
      input  digit_valid, digit_in, backspace, clear, commit,
      output digits, digit_count, busy, value, done, range_err
   );
endinterface

// File: rtl/decimal_entry_parser.sv
// Editable decimal digit buffer with serial decimal-to-binary conversion on commit,
// followed by a range check that clamps the result into [MIN_VAL, MAX_VAL].
module decimal_entry_parser #(
   parameter int          DIGITS  = 2,
   parameter int          W_OUT   = 8,
   parameter int unsigned MIN_VAL = 1,
   parameter int unsigned MAX_VAL = 99
) (
   input logic                 clk,
   input logic                 rst_n,
   decimal_entry_parser_if.slave bus
);
   function automatic int unsigned pow10(input int n);
      int unsigned p;
      p = 1;
      for (int k = 0; k < n; k++) p = p * 10;
      return p;
   endfunction

   localparam int unsigned POW10 = pow10(DIGITS);
   localparam int          AW    = $clog2(POW10);
   localparam int          IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {EDIT, CONVERT, CHECK} state_t;

   state_t                 state_q, state_d;
   logic [DIGITS-1:0][3:0] digits_q, digits_d;
   logic [2:0]             count_q, count_d;
   logic [AW-1:0]          acc_q, acc_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic                   busy_q, busy_d;
   logic [W_OUT-1:0]       value_q, value_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic                   to_check, empty;
   logic [AW-1:0]          acc_step;

   // acc*10 as two shifts; every partial value stays below 10^DIGITS, so AW bits suffice
   assign acc_step = (acc_q << 3) + (acc_q << 1) + AW'(digits_q[idx_q]);

   always_comb begin
      state_d  = state_q;
      digits_d = digits_q;
      count_d  = count_q;
      acc_d    = acc_q;
      idx_d    = idx_q;
      busy_d   = busy_q;
      value_d  = value_q;
      done_d   = 1'b0;
      err_d    = err_q;
      to_check = 1'b0;
      empty    = 1'b0;
      case (state_q)
         EDIT: begin
            if (bus.clear) begin
               digits_d = '0;
               count_d  = 3'd0;
               err_d    = 1'b0;
            end else if (bus.commit) begin
               acc_d  = '0;
               busy_d = 1'b1;
               if (count_q == 3'd0) begin
                  empty    = 1'b1;
                  to_check = 1'b1;
                  state_d  = CHECK;
               end else begin
                  idx_d   = IW'(count_q - 3'd1);
                  state_d = CONVERT;
               end
            end else if (bus.backspace) begin
               if (count_q != 3'd0) begin
                  for (int k = 0; k < DIGITS - 1; k++) digits_d[k] = digits_q[k+1];
                  digits_d[DIGITS-1] = 4'h0;
                  count_d = count_q - 3'd1;
               end
            end else if (bus.digit_valid) begin
               if (bus.digit_in <= 4'd9 && count_q < 3'(DIGITS)) begin
                  for (int k = DIGITS - 1; k > 0; k--) digits_d[k] = digits_q[k-1];
                  digits_d[0] = bus.digit_in;
                  count_d = count_q + 3'd1;
               end
            end
         end
         CONVERT: begin
            acc_d = acc_step;
            idx_d = idx_q - IW'(1);
            if (idx_q == '0) begin
               to_check = 1'b1;
               state_d  = CHECK;
            end
         end
         CHECK: begin
            busy_d  = 1'b0;
            state_d = EDIT;
         end
         default: state_d = EDIT;
      endcase

      // Result is registered on entry to CHECK so done and value appear together
      if (to_check) begin
         done_d = 1'b1;
         if (empty || acc_d < AW'(MIN_VAL)) begin
            value_d = W_OUT'(MIN_VAL);
            err_d   = 1'b1;
         end else if (acc_d > AW'(MAX_VAL)) begin
            value_d = W_OUT'(MAX_VAL);
            err_d   = 1'b1;
         end else begin
            value_d = W_OUT'(acc_d);
            err_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= EDIT;
         digits_q <= '0;
         count_q  <= 3'd0;
         acc_q    <= '0;
         idx_q    <= '0;
         busy_q   <= 1'b0;
         value_q  <= W_OUT'(MIN_VAL);
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         digits_q <= digits_d;
         count_q  <= count_d;
         acc_q    <= acc_d;
         idx_q    <= idx_d;
         busy_q   <= busy_d;
         value_q  <= value_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign bus.digits      = digits_q;
   assign bus.digit_count = count_q;
   assign bus.busy        = busy_q;
   assign bus.value       = value_q;
   assign bus.done        = done_q;
   assign bus.range_err   = err_q;
endmodule

// File: tb/tb_decimal_entry_parser.sv
// Bench for decimal_entry_parser: two instances (MAX 99 and MAX 20) share one stimulus
// stream and are checked against a queue-based model, a directed table and corner sequences.
module tb_decimal_entry_parser;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   decimal_entry_parser_if #(.DIGITS(2), .W_OUT(8)) ifa ();
   decimal_entry_parser_if #(.DIGITS(2), .W_OUT(8)) ifb ();

   decimal_entry_parser dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
   decimal_entry_parser #(.DIGITS(2), .W_OUT(8), .MIN_VAL(1), .MAX_VAL(20)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

   int n_tests = 0;
   int n_fail  = 0;

   // model: entered digits (most significant first) and remaining busy cycles
   int q[$];
   int ph;
   bit done_m;
   int val_a, err_a, val_b, err_b;

   typedef struct {
      bit dv; int din; bit bs; bit clr; bit cm;
      int e_dig; int e_cnt; int e_busy; int e_done; int e_val; int e_err;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   task automatic drive(input bit dv, input int din, input bit bs, input bit clr, input bit cm);
      ifa.digit_valid = dv; ifa.digit_in = 4'(din); ifa.backspace = bs; ifa.clear = clr; ifa.commit = cm;
      ifb.digit_valid = dv; ifb.digit_in = 4'(din); ifb.backspace = bs; ifb.clear = clr; ifb.commit = cm;
   endtask

   task automatic model_reset();
      q.delete();
      ph = 0; done_m = 0;
      val_a = 1; err_a = 0; val_b = 1; err_b = 0;
   endtask

   function automatic int exp_digits();
      int d;
      d = 0;
      for (int k = 0; k < q.size(); k++) d = d | (q[q.size()-1-k] << (4*k));
      return d;
   endfunction

   task automatic clamp(input int num, input bit empty, input int mx, output int v, output int e);
      if (empty || num < 1) begin v = 1; e = 1; end
      else if (num > mx) begin v = mx; e = 1; end
      else begin v = num; e = 0; end
   endtask

   task automatic model_edge(input bit dv, input int din, input bit bs, input bit clr, input bit cm);
      int num;
      if (ph > 0) ph--;
      else if (clr) begin q.delete(); err_a = 0; err_b = 0; end
      else if (cm) ph = q.size() + 1;
      else if (bs) begin if (q.size() > 0) void'(q.pop_back()); end
      else if (dv && din <= 9 && q.size() < 2) q.push_back(din);
      done_m = (ph == 1);
      if (done_m) begin
         num = 0;
         foreach (q[k]) num = num * 10 + q[k];
         clamp(num, q.size() == 0, 99, val_a, err_a);
         clamp(num, q.size() == 0, 20, val_b, err_b);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".a.digits"}, int'(ifa.digits), exp_digits());
      chk({tag, ".a.count"},  int'(ifa.digit_count), q.size());
      chk({tag, ".a.busy"},   int'(ifa.busy), int'(ph > 0));
      chk({tag, ".a.done"},   int'(ifa.done), int'(done_m));
      chk({tag, ".a.value"},  int'(ifa.value), val_a);
      chk({tag, ".a.err"},    int'(ifa.range_err), err_a);
      chk({tag, ".b.digits"}, int'(ifb.digits), exp_digits());
      chk({tag, ".b.count"},  int'(ifb.digit_count), q.size());
      chk({tag, ".b.busy"},   int'(ifb.busy), int'(ph > 0));
      chk({tag, ".b.done"},   int'(ifb.done), int'(done_m));
      chk({tag, ".b.value"},  int'(ifb.value), val_b);
      chk({tag, ".b.err"},    int'(ifb.range_err), err_b);
   endtask

   task automatic cycle(input string tag, input bit dv, input int din, input bit bs, input bit clr, input bit cm);
      drive(dv, din, bs, clr, cm);
      @(posedge clk);
      model_edge(dv, din, bs, clr, cm);
      #1;
      check_all(tag);
   endtask

   task automatic v(input bit dv, input int din, input bit bs, input bit clr, input bit cm,
                    input int dig, input int cnt, input int busy, input int done, input int val, input int err);
      vec_t t;
      t = '{dv, din, bs, clr, cm, dig, cnt, busy, done, val, err};
      tbl.push_back(t);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // directed sequence for the MAX=99 instance
      v(1,4,0,0,0, 'h04,1,0,0, 1,0);
      v(1,2,0,0,0, 'h42,2,0,0, 1,0);
      v(0,0,0,0,1, 'h42,2,1,0, 1,0);
      v(0,0,0,0,0, 'h42,2,1,0, 1,0);
      v(0,0,0,0,0, 'h42,2,1,1,42,0);
      v(0,0,0,0,0, 'h42,2,0,0,42,0);
      v(0,0,0,1,0, 'h00,0,0,0,42,0);
      v(1,0,0,0,0, 'h00,1,0,0,42,0);
      v(0,0,0,0,1, 'h00,1,1,0,42,0);
      v(0,0,0,0,0, 'h00,1,1,1, 1,1);
      v(0,0,0,0,0, 'h00,1,0,0, 1,1);
      v(0,0,0,1,0, 'h00,0,0,0, 1,0);
      v(1,1,0,0,0, 'h01,1,0,0, 1,0);
      v(1,2,0,0,0, 'h12,2,0,0, 1,0);
      v(1,3,0,0,0, 'h12,2,0,0, 1,0);
      v(0,0,1,0,0, 'h01,1,0,0, 1,0);
      v(1,5,0,0,0, 'h15,2,0,0, 1,0);
      v(0,0,0,0,1, 'h15,2,1,0, 1,0);
      v(0,0,0,0,0, 'h15,2,1,0, 1,0);
      v(0,0,0,0,0, 'h15,2,1,1,15,0);
      v(0,0,0,0,0, 'h15,2,0,0,15,0);
      v(0,0,0,1,0, 'h00,0,0,0,15,0);
      v(1,12,0,0,0,'h00,0,0,0,15,0);
      v(0,0,0,0,1, 'h00,0,1,1, 1,1);
      v(0,0,0,0,0, 'h00,0,0,0, 1,1);
      v(1,9,0,0,0, 'h09,1,0,0, 1,1);
      v(1,9,0,0,0, 'h99,2,0,0, 1,1);
      v(0,0,0,0,1, 'h99,2,1,0, 1,1);
      v(0,0,0,1,0, 'h99,2,1,0, 1,1);
      v(0,0,1,0,0, 'h99,2,1,1,99,0);
      v(1,1,0,0,0, 'h99,2,0,0,99,0);
      v(0,0,0,1,0, 'h00,0,0,0,99,0);

      drive(0, 0, 0, 0, 0);
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         cycle($sformatf("vec%0d", i), tbl[i].dv, tbl[i].din, tbl[i].bs, tbl[i].clr, tbl[i].cm);
         chk($sformatf("tbl%0d.digits", i), int'(ifa.digits), tbl[i].e_dig);
         chk($sformatf("tbl%0d.count", i),  int'(ifa.digit_count), tbl[i].e_cnt);
         chk($sformatf("tbl%0d.busy", i),   int'(ifa.busy), tbl[i].e_busy);
         chk($sformatf("tbl%0d.done", i),   int'(ifa.done), tbl[i].e_done);
         chk($sformatf("tbl%0d.value", i),  int'(ifa.value), tbl[i].e_val);
         chk($sformatf("tbl%0d.err", i),    int'(ifa.range_err), tbl[i].e_err);
      end
      chk("max20.value", int'(ifb.value), 20);
      chk("max20.err_cleared", int'(ifb.range_err), 0);

      // reset in the middle of a conversion
      cycle("r77a", 1, 7, 0, 0, 0);
      cycle("r77b", 1, 7, 0, 0, 0);
      cycle("rcm",  0, 0, 0, 0, 1);
      cycle("rcv",  0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("rst_mid");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("rst_hold.done_a", int'(ifa.done), 0);
         chk("rst_hold.done_b", int'(ifb.done), 0);
         chk("rst_hold.busy_a", int'(ifa.busy), 0);
      end
      @(negedge clk) rst_n = 1'b1;
      cycle("k3",   1, 3, 0, 0, 0);
      cycle("c3",   0, 0, 0, 0, 1);
      cycle("w3",   0, 0, 0, 0, 0);
      cycle("d3",   0, 0, 0, 0, 0);
      chk("after_rst.value", int'(ifa.value), 3);

      // randomized strobes, possibly several at once
      for (int i = 0; i < 600; i++) begin
         cycle($sformatf("rnd%0d", i),
               bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
               bit'($urandom_range(0, 5) == 0), bit'($urandom_range(0, 11) == 0),
               bit'($urandom_range(0, 5) == 0));
      end
      drive(0, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
